// File: rtl/seq_divider_pkg.sv
// rtl/seq_divider_pkg.sv - shared state encoding and constants for seq_divider (signed mode: SEQ_DIV_SIGNED_EN)
package seq_divider_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } div_state_t;

  localparam int DIV_MAX_N = 64;

  // Quotient reported for a zero divisor, sliced to the operand width by the user.
  localparam logic [DIV_MAX_N-1:0] DIV0_Q = '1;

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/seq_divider_sub_stage.sv
// rtl/seq_divider_sub_stage.sv - div_sub_stage: a - b as a + ~b + 1 with generate/propagate carries
module div_sub_stage #(
  parameter int W = 33
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] diff,
  output logic         nonneg
);

  logic [W-1:0] nb;
  logic [W-1:0] g;
  logic [W-1:0] p;
  logic [W:0]   c;

  always_comb begin
    nb   = ~b;
    g    = a & nb;
    p    = a ^ nb;
    c    = '0;
    c[0] = 1'b1;
    for (int i = 0; i < W; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
    diff   = p ^ c[W-1:0];
    // Carry out of a + ~b + 1 means no borrow, i.e. a >= b.
    nonneg = c[W];
  end

endmodule

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - radix-2 restoring divider, one quotient bit per clock (signed mode: SEQ_DIV_SIGNED_EN)
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  input  logic         is_signed,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] q,
  output logic [N-1:0] r,
  output logic         div0
);

  localparam int CW = cnt_width(N);

  div_state_t    state;
  logic [N-1:0]  pr;
  logic [N-1:0]  w;
  logic [N-1:0]  d;
  logic [CW-1:0] cnt;

  logic [N:0]    t_a;
  logic [N:0]    t_diff;
  logic          t_nonneg;
  logic [N-1:0]  pr_next;
  logic [N-1:0]  w_next;
  logic [N-1:0]  a_mag;
  logic [N-1:0]  b_mag;
  logic          unused_diff_msb;

`ifdef SEQ_DIV_SIGNED_EN
  logic op_signed;
  logic neg_q;
  logic neg_r;

  assign a_mag = (is_signed && dividend[N-1]) ? -dividend : dividend;
  assign b_mag = (is_signed && divisor[N-1])  ? -divisor  : divisor;
`else
  logic unused_signed;

  assign unused_signed = is_signed;
  assign a_mag         = dividend;
  assign b_mag         = divisor;
`endif

  assign t_a = {pr, w[N-1]};

  div_sub_stage #(.W(N + 1)) u_sub (
    .a      (t_a),
    .b      ({1'b0, d}),
    .diff   (t_diff),
    .nonneg (t_nonneg)
  );

  // A negative trial keeps the shifted value, which always fits in N bits then.
  assign pr_next         = t_nonneg ? t_diff[N-1:0] : t_a[N-1:0];
  assign w_next          = {w[N-2:0], t_nonneg};
  assign unused_diff_msb = t_diff[N];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      q         <= '0;
      r         <= '0;
      div0      <= 1'b0;
      pr        <= '0;
      w         <= '0;
      d         <= '0;
      cnt       <= '0;
`ifdef SEQ_DIV_SIGNED_EN
      op_signed <= 1'b0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            in_ready <= 1'b0;
            if (divisor == '0) begin
              q         <= DIV0_Q[N-1:0];
              r         <= dividend;
              div0      <= 1'b1;
              out_valid <= 1'b1;
              state     <= S_DONE;
            end else begin
              div0  <= 1'b0;
              pr    <= '0;
              w     <= a_mag;
              d     <= b_mag;
              cnt   <= CW'(N);
              state <= S_CALC;
`ifdef SEQ_DIV_SIGNED_EN
              op_signed <= is_signed;
              neg_q     <= is_signed & (dividend[N-1] ^ divisor[N-1]);
              neg_r     <= is_signed & dividend[N-1];
`endif
            end
          end
        end
        S_CALC: begin
          pr  <= pr_next;
          w   <= w_next;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
`ifdef SEQ_DIV_SIGNED_EN
            if (op_signed) begin
              state <= S_FIX;
            end else begin
              q         <= w_next;
              r         <= pr_next;
              out_valid <= 1'b1;
              state     <= S_DONE;
            end
`else
            q         <= w_next;
            r         <= pr_next;
            out_valid <= 1'b1;
            state     <= S_DONE;
`endif
          end
        end
`ifdef SEQ_DIV_SIGNED_EN
        S_FIX: begin
          q         <= neg_q ? -w : w;
          r         <= neg_r ? -pr : pr;
          out_valid <= 1'b1;
          state     <= S_DONE;
        end
`endif
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - self-checking bench for seq_divider (N=8 directed, N=32 random stream)
module tb_seq_divider;

`ifdef SEQ_DIV_SIGNED_EN
  localparam bit SIGNED_BUILD = 1'b1;
`else
  localparam bit SIGNED_BUILD = 1'b0;
`endif
  localparam int NRAND = 40;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        sgn;
  logic        iv8, ir8, ov8, or8, dz8;
  logic [7:0]  a8, b8, q8, r8;
  logic        iv32, ir32, ov32, or32, dz32;
  logic [31:0] a32, b32, q32, r32;

  seq_divider #(.N(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8),
    .dividend(a8), .divisor(b8), .is_signed(sgn),
    .out_valid(ov8), .out_ready(or8), .q(q8), .r(r8), .div0(dz8)
  );

  seq_divider #(.N(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32),
    .dividend(a32), .divisor(b32), .is_signed(sgn),
    .out_valid(ov32), .out_ready(or32), .q(q32), .r(r32), .div0(dz32)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       s;
    logic [7:0] eq;
    logic [7:0] er;
    logic       ed;
    int         lat;
  } vec_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] eq;
    logic [31:0] er;
    logic        ed;
  } rec_t;

  vec_t vecs[$];
  vec_t exp8_q[$];
  rec_t exp32_q[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
    end
  endtask

  task automatic model32(input logic [31:0] a, input logic [31:0] b, input logic s,
                         output logic [31:0] eq, output logic [31:0] er, output logic ed);
    ed = (b == 32'd0);
    if (b == 32'd0) begin
      eq = '1;
      er = a;
    end else if (s && SIGNED_BUILD) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        eq = a;
        er = 32'd0;
      end else begin
        eq = $signed(a) / $signed(b);
        er = $signed(a) % $signed(b);
      end
    end else begin
      eq = a / b;
      er = a % b;
    end
  endtask

  task automatic run_op8(input string tag, input vec_t v);
    int   k;
    vec_t e;
    @(negedge clk);
    check({tag, "_in_ready_idle"}, ir8, 1);
    a8  = v.a;
    b8  = v.b;
    sgn = v.s;
    iv8 = 1'b1;
    exp8_q.push_back(v);
    @(posedge clk);
    @(negedge clk);
    iv8 = 1'b0;
    a8  = 8'($urandom);
    b8  = 8'($urandom);
    sgn = ~sgn;
    k = 0;
    while (!ov8 && k < 200) begin
      @(posedge clk);
      k++;
      @(negedge clk);
    end
    e = exp8_q.pop_front();
    check({tag, "_latency"}, k, e.lat);
    check({tag, "_q"}, q8, e.eq);
    check({tag, "_r"}, r8, e.er);
    check({tag, "_div0"}, dz8, e.ed);
    check({tag, "_in_ready_busy"}, ir8, 0);
    or8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    or8 = 1'b0;
    check({tag, "_out_valid_clr"}, ov8, 0);
    check({tag, "_in_ready_back"}, ir8, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rst_n = 1'b0;
    sgn = 1'b0;
    iv8 = 1'b0; or8 = 1'b0; a8 = '0; b8 = '0;
    iv32 = 1'b0; or32 = 1'b0; a32 = '0; b32 = '0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", ir8, 1);
    check("rst_out_valid", ov8, 0);
    check("rst_q", q8, 0);
    check("rst_r", r8, 0);
    check("rst_div0", dz8, 0);
    rst_n = 1'b1;

    vecs.push_back('{8'd200, 8'd7,   1'b0, 8'd28,  8'd4,   1'b0, 8});
    vecs.push_back('{8'h5A,  8'd0,   1'b0, 8'hFF,  8'h5A,  1'b1, 0});
    vecs.push_back('{8'd255, 8'd1,   1'b0, 8'd255, 8'd0,   1'b0, 8});
    vecs.push_back('{8'd5,   8'd9,   1'b0, 8'd0,   8'd5,   1'b0, 8});
    vecs.push_back('{8'd255, 8'd255, 1'b0, 8'd1,   8'd0,   1'b0, 8});
    vecs.push_back('{8'd0,   8'd3,   1'b0, 8'd0,   8'd0,   1'b0, 8});
    vecs.push_back('{8'd128, 8'd16,  1'b0, 8'd8,   8'd0,   1'b0, 8});
    vecs.push_back('{8'd254, 8'd255, 1'b0, 8'd0,   8'd254, 1'b0, 8});
`ifdef SEQ_DIV_SIGNED_EN
    vecs.push_back('{8'hF9,  8'h02,  1'b1, 8'hFD,  8'hFF,  1'b0, 9});
    vecs.push_back('{8'h80,  8'hFF,  1'b1, 8'h80,  8'h00,  1'b0, 9});
    vecs.push_back('{8'h07,  8'hFE,  1'b1, 8'hFD,  8'h01,  1'b0, 9});
    vecs.push_back('{8'hF9,  8'hFE,  1'b1, 8'h03,  8'hFF,  1'b0, 9});
    vecs.push_back('{8'h85,  8'h00,  1'b1, 8'hFF,  8'h85,  1'b1, 0});
`else
    vecs.push_back('{8'hF9,  8'h02,  1'b1, 8'h7C,  8'h01,  1'b0, 8});
`endif
    foreach (vecs[i]) run_op8($sformatf("v%0d", i), vecs[i]);

    // Backpressure: result must hold and new operands must be refused.
    @(negedge clk);
    a8 = 8'd100; b8 = 8'd7; sgn = 1'b0; iv8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv8 = 1'b0;
    k = 0;
    while (!ov8 && k < 200) begin
      @(negedge clk);
      k++;
    end
    for (int c = 0; c < 5; c++) begin
      check($sformatf("bp%0d_out_valid", c), ov8, 1);
      check($sformatf("bp%0d_q", c), q8, 8'd14);
      check($sformatf("bp%0d_r", c), r8, 8'd2);
      check($sformatf("bp%0d_in_ready", c), ir8, 0);
      iv8 = 1'b1;
      a8  = 8'($urandom);
      b8  = 8'($urandom_range(1, 255));
      @(posedge clk);
      @(negedge clk);
    end
    or8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv8 = 1'b0;
    or8 = 1'b0;
    check("bp_hs_out_valid", ov8, 0);
    check("bp_hs_not_accepted", ir8, 1);

    // Reset in the middle of an iteration aborts it.
    @(negedge clk);
    a8 = 8'd200; b8 = 8'd7; iv8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv8 = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", ir8, 1);
    check("mid_rst_out_valid", ov8, 0);
    check("mid_rst_q", q8, 0);
    check("mid_rst_r", r8, 0);
    check("mid_rst_div0", dz8, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op8("post_rst", '{8'd100, 8'd10, 1'b0, 8'd10, 8'd0, 1'b0, 8});

    // N=32 random stream with random backpressure.
    fork
      begin : driver
        rec_t rc;
        int   t;
        logic s;
        for (int i = 0; i < NRAND; i++) begin
          @(negedge clk);
          t = 0;
          while (!ir32 && t < 500) begin
            @(negedge clk);
            t++;
          end
          check("drv_ready_wait", ir32, 1);
          if (!ir32) break;
          rc.a = $urandom;
          case ($urandom_range(0, 7))
            0: rc.b = 32'd0;
            1: rc.b = 32'($urandom_range(1, 15));
            2: rc.b = 32'hFFFF_FFFF;
            3: begin
              rc.a = 32'h8000_0000;
              rc.b = ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFF : 32'd1;
            end
            default: rc.b = $urandom >> $urandom_range(0, 31);
          endcase
          s = 1'($urandom_range(0, 1));
          model32(rc.a, rc.b, s, rc.eq, rc.er, rc.ed);
          exp32_q.push_back(rc);
          a32 = rc.a; b32 = rc.b; sgn = s; iv32 = 1'b1;
          @(posedge clk);
          #1;
          iv32 = 1'b0;
          a32  = $urandom;
          b32  = $urandom;
        end
      end
      begin : monitor
        rec_t        rc;
        int          got;
        int          tmo;
        logic [31:0] inv;
        got = 0;
        tmo = 0;
        while (got < NRAND && tmo < 20000) begin
          @(negedge clk);
          tmo++;
          or32 = ($urandom_range(0, 2) != 0);
          if (ov32 && or32) begin
            if (exp32_q.size() == 0) begin
              check("rand_unexpected_result", ov32, 0);
            end else begin
              rc = exp32_q.pop_front();
              check($sformatf("rand%0d_q", got), q32, rc.eq);
              check($sformatf("rand%0d_r", got), r32, rc.er);
              check($sformatf("rand%0d_div0", got), dz32, rc.ed);
              if (rc.b != 32'd0) begin
                inv = q32 * rc.b + r32;
                check($sformatf("rand%0d_invariant", got), inv, rc.a);
              end
            end
            got++;
          end
        end
        or32 = 1'b0;
        check("rand_result_count", got, NRAND);
      end
    join

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
# seq_divider

Multi-cycle radix-2 restoring divider, the inverse operation to the MAC datapath's multiply/add path. It accepts an N-bit dividend/divisor pair over a valid/ready handshake. It produces one quotient bit per clock using an (N+1)-bit subtract stage, then returns quotient and remainder over a second valid/ready handshake. It sits beside the MAC unit and shares its operand widths.

## Interface
- N, 32: operand, quotient and remainder width; legal range 4..64.
- CLK  input  1  rising-edge clock.
- RST_N  input  1  asynchronous active-low reset.
- IN_VALID  input  1  operand pair valid.
- IN_READY  output  1  divider idle, able to accept.
- DIVIDEND  input  N  numerator.
- DIVISOR  input  N  denominator.
- SIGNED  input  1  two's-complement operation; used only when SEQ_DIV_SIGNED_EN is defined.
- OUT_VALID  output  1  result valid.
- OUT_READY  input  1  consumer accepts result.
- Q  output  N  quotient.
- R  output  N  remainder.
- DIV0  output  1  result came from a zero divisor.

## Operation
- States:
  - IDLE: IN_READY=1.
  - CALC: iterating.
  - FIX: signed sign correction; exists only with the macro.
  - DONE: OUT_VALID=1.
- IDLE→CALC on the accept edge (IN_VALID & IN_READY) when DIVISOR≠0.
  - Load partial remainder PR=0, working quotient W=|DIVIDEND|, divisor register D=|DIVISOR|, step counter=N.
- IDLE→DONE on the accept edge when DIVISOR==0.
  - Q=all-ones, R=DIVIDEND unchanged, DIV0=1.
- Each CALC cycle:
  - T={PR[N-1:0],W[N-1]} − {1'b0,D}, computed (N+1) bits wide.
  - If T is non-negative: PR=T, quotient bit 1. Otherwise PR is restored (shifted value kept), quotient bit 0.
  - W shifts left with the quotient bit entering at the LSB.
  - Counter decrements.
- When the counter reaches 1: CALC→DONE (unsigned) or CALC→FIX (signed).
- FIX:
  - Negate Q if sign(DIVIDEND)^sign(DIVISOR).
  - Negate R if sign(DIVIDEND).
  - Then →DONE.
- DONE→IDLE on OUT_VALID & OUT_READY. Q/R/DIV0 hold their values until the next accept.
- Operands are registered on accept. Input changes during CALC/FIX have no effect.
- Invariant for nonzero divisor: DIVIDEND == Q*DIVISOR + R, with |R| < |DIVISOR|, modulo 2^N.
- Signed overflow (most-negative ÷ −1): Q=most-negative (wraps), R=0, DIV0=0.

## Timing
- Reset values: IN_READY=1, OUT_VALID=0, Q=0, R=0, DIV0=0, state IDLE.
- Latency from the accept edge t to OUT_VALID high:
  - Unsigned: after edge t+N.
  - Signed: after edge t+N+1.
  - Zero divisor: after edge t.
- IN_READY is low from the accept edge until the result handshake edge. There is no overlap of consecutive operations.
- Back-to-back throughput: a new accept is possible on the cycle after the result handshake.
- OUT_VALID stays high while OUT_READY is low. Q/R stay stable during backpressure.
- Reset asserted mid-CALC/FIX/DONE: immediate abort to reset values. The pending result is discarded.
- IN_VALID in the same cycle as the result handshake is not accepted, because IN_READY is still low.

## Configuration
- SEQ_DIV_SIGNED_EN defined:
  - The SIGNED input selects signed operation.
  - Magnitudes are taken on load and the FIX state is present.
  - Signed zero-divisor result: Q=all-ones, R=DIVIDEND.
- SEQ_DIV_SIGNED_EN undefined:
  - SIGNED is ignored and the FIX state and negation logic are absent.
  - All operations are unsigned, with latency N.

## Structure
- Shared package: state encoding typedef (IDLE, CALC, FIX, DONE), counter width constant $clog2(N+1), and the zero-divisor quotient constant.
- Sub-module div_sub_stage: (N+1)-bit subtract producing difference and non-negative flag.
  - Implemented as add of the inverted operand with carry-in 1, carry-lookahead style.
- Top level holds the FSM, registers and handshakes.

## Test plan
- N=8 unsigned: 200 ÷ 7 → Q=28, R=4, DIV0=0, with OUT_VALID after exactly 8 edges post-accept.
- N=8 divisor 0: DIVIDEND=0x5A → Q=0xFF, R=0x5A, DIV0=1, with OUT_VALID after the accept edge.
- N=8 signed (macro on):
  - −7 ÷ 2 → Q=−3 (0xFD), R=−1 (0xFF).
  - −128 ÷ −1 → Q=0x80, R=0.
  - Latency 9.
- Backpressure: hold OUT_READY=0 for 5 cycles in DONE → OUT_VALID and Q/R stable, IN_READY=0, extra IN_VALID pulses ignored.
- Assert RST_N low mid-CALC (step 4) → all outputs at reset values immediately. The next accept of 100 ÷ 10 yields Q=10, R=0.
- Random N=32 unsigned and signed stream under random backpressure → every result matches the reference model and the invariant DIVIDEND == Q*DIVISOR + R.
